// File: rtl/hamming_ecc_mem_ctrl_if.sv
// +----------------------------------------------------------------------+
// | hamming_ecc_mem_ctrl_if : request/response bundle for the ECC memory |
// | controller.                                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface hamming_ecc_mem_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic [11:0]       req_inj;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_corrected;
  logic              rsp_uncorr;
  logic [3:0]        rsp_syndrome;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_inj,
    input  req_ready, rsp_valid, rsp_rdata, rsp_corrected, rsp_uncorr,
           rsp_syndrome, err_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_inj,
    output req_ready, rsp_valid, rsp_rdata, rsp_corrected, rsp_uncorr,
           rsp_syndrome, err_count
  );
endinterface

`default_nettype wire

// File: rtl/hamming_ecc_mem_ctrl.sv
// +----------------------------------------------------------------------+
// | hamming_ecc_mem_ctrl : Hamming(12,8) protected scratch memory with   |
// | read-correct-scrub sequencing and write-side error injection.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hamming_ecc_mem_ctrl #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_ecc_mem_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CHK  = 3'd3,
    WB   = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic              accept;

  logic              ready_q;
  logic              op_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [11:0]       inj_q;
  logic [11:0]       rd_word_q;
  logic [11:0]       fix_word_q;
  logic [3:0]        syn_q;

  logic [3:0]        syn_comb;
  logic              correctable;
  logic              uncorrectable;
  logic [11:0]       fix_comb;

  logic              rsp_valid_q;
  logic [7:0]        rsp_rdata_q;
  logic              rsp_corrected_q;
  logic              rsp_uncorr_q;
  logic [3:0]        rsp_syndrome_q;
  logic [CNT_W-1:0]  err_count_q;

  logic [11:0]       mem [DEPTH];

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7:4], p[3], d[3:1], p[2], d[0], p[1], p[0]};
  endfunction

  function automatic logic [3:0] syndrome(input logic [11:0] c);
    return {^c[11:7],
            c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11],
            c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10],
            c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10]};
  endfunction

  function automatic logic [7:0] extract(input logic [11:0] c);
    return {c[11:8], c[6:4], c[2]};
  endfunction

  // Syndrome 1..12 names the faulty bit position; 13..15 cannot be a single flip.
  always_comb begin
    syn_comb      = syndrome(rd_word_q);
    correctable   = (syn_comb != 4'd0) && (syn_comb <= 4'd12);
    uncorrectable = (syn_comb >= 4'd13);
    fix_comb      = rd_word_q;
    if (correctable) begin
      fix_comb = rd_word_q ^ (12'd1 << (syn_comb - 4'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = bus.req_we ? WR : RD;
        end
      end
      WR:      state_nxt = RSP;
      RD:      state_nxt = CHK;
      CHK:     state_nxt = correctable ? WB : RSP;
      WB:      state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q         <= 1'b0;
      op_we_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= 8'd0;
      inj_q           <= 12'd0;
      rd_word_q       <= 12'd0;
      fix_word_q      <= 12'd0;
      syn_q           <= 4'd0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 8'd0;
      rsp_corrected_q <= 1'b0;
      rsp_uncorr_q    <= 1'b0;
      rsp_syndrome_q  <= 4'd0;
      err_count_q     <= '0;
    end else begin
      ready_q     <= (state_nxt == IDLE);
      rsp_valid_q <= (state_nxt == RSP);

      if (accept) begin
        op_we_q <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        inj_q   <= bus.req_inj;
      end

      if (state_q == RD) begin
        rd_word_q <= mem[addr_q];
      end

      if (state_q == CHK) begin
        syn_q      <= syn_comb;
        fix_word_q <= fix_comb;
        if (correctable && (err_count_q != {CNT_W{1'b1}})) begin
          err_count_q <= err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      // Response fields change only when a new response is about to be presented.
      if (state_nxt == RSP) begin
        case (state_q)
          CHK: begin
            rsp_rdata_q     <= extract(rd_word_q);
            rsp_syndrome_q  <= syn_comb;
            rsp_corrected_q <= 1'b0;
            rsp_uncorr_q    <= uncorrectable;
          end
          WB: begin
            rsp_rdata_q     <= extract(fix_word_q);
            rsp_syndrome_q  <= syn_q;
            rsp_corrected_q <= 1'b1;
            rsp_uncorr_q    <= 1'b0;
          end
          default: begin
            rsp_rdata_q     <= 8'd0;
            rsp_syndrome_q  <= 4'd0;
            rsp_corrected_q <= 1'b0;
            rsp_uncorr_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stores are gated by rst_n so a reset cycle never commits a pending write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == WR) begin
        mem[addr_q] <= encode(wdata_q) ^ inj_q;
      end else if (state_q == WB) begin
        mem[addr_q] <= fix_word_q;
      end
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_corrected = rsp_corrected_q;
  assign bus.rsp_uncorr    = rsp_uncorr_q;
  assign bus.rsp_syndrome  = rsp_syndrome_q;
  assign bus.err_count     = err_count_q;

  // Write data only matters as a store source; keep the flag readable for debug.
  logic unused_we;
  assign unused_we = op_we_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_ecc_mem_ctrl.sv
// Directed and randomized checks of hamming_ecc_mem_ctrl against a position-based
// Hamming reference model (parity at power-of-two positions, syndrome = XOR of set positions).
`default_nettype none

module tb_hamming_ecc_mem_ctrl;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hamming_ecc_mem_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  hamming_ecc_mem_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [11:0] model_mem [16];
  bit          model_valid [16];
  int          model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic logic [11:0] model_enc(input logic [7:0] d);
    logic [11:0] c;
    logic [3:0]  acc;
    int          k;
    c = '0; acc = '0; k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos-1] = d[k];
        if (d[k]) acc ^= 4'(pos);
        k++;
      end
    end
    for (int j = 0; j < 4; j++) c[(1 << j) - 1] = acc[j];
    return c;
  endfunction

  function automatic int model_syn(input logic [11:0] c);
    int acc;
    acc = 0;
    for (int i = 0; i < 12; i++) if (c[i]) acc ^= (i + 1);
    return acc;
  endfunction

  function automatic logic [7:0] model_data(input logic [11:0] c);
    logic [7:0] d;
    int         k;
    d = '0; k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic model_read(input logic [3:0] a, output logic [7:0] rd, output logic [3:0] syn,
                            output logic corr, output logic unc);
    logic [11:0] c;
    int          s;
    c = model_mem[a];
    s = model_syn(c);
    syn = 4'(s); corr = 1'b0; unc = 1'b0;
    if (s >= 1 && s <= 12) begin
      c[s-1] = ~c[s-1];
      model_mem[a] = c;
      corr = 1'b1;
      if (model_cnt < 65535) model_cnt++;
    end else if (s >= 13) begin
      unc = 1'b1;
    end
    rd = model_data(c);
  endtask

  task automatic transact(input string tag, input logic we, input logic [3:0] a, input logic [7:0] wd,
                          input logic [11:0] inj, input int exp_lat, input logic [7:0] e_rd,
                          input logic [3:0] e_syn, input logic e_corr, input logic e_unc);
    int wait_n;
    int lat;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_inj   = inj;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, 32'(bus.rsp_rdata), 32'(e_rd));
    check({tag, " syndrome"}, 32'(bus.rsp_syndrome), 32'(e_syn));
    check({tag, " corrected"}, 32'(bus.rsp_corrected), 32'(e_corr));
    check({tag, " uncorr"}, 32'(bus.rsp_uncorr), 32'(e_unc));
    check({tag, " err_count"}, 32'(bus.err_count), 32'(model_cnt));
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d, input logic [11:0] inj);
    model_mem[a]   = model_enc(d) ^ inj;
    model_valid[a] = 1'b1;
    transact(tag, 1'b1, a, d, inj, 2, 8'h00, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a);
    logic [7:0] rd;
    logic [3:0] s;
    logic       c;
    logic       u;
    model_read(a, rd, s, c, u);
    transact(tag, 1'b0, a, 8'h00, 12'h000, c ? 4 : 3, rd, s, c, u);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check({tag, " syndrome"}, 32'(bus.rsp_syndrome), 32'd0);
    check({tag, " flags"}, 32'({bus.rsp_corrected, bus.rsp_uncorr}), 32'd0);
    check({tag, " err_count"}, 32'(bus.err_count), 32'd0);
  endtask

  task automatic release_reset(input string tag);
    rst_n = 1'b1;
    model_cnt = 0;
    @(posedge clk); #1;
    check({tag, " ready after release"}, 32'(bus.req_ready), 32'd1);
    check({tag, " no rsp after release"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  // Holds reset for a few cycles starting now and confirms no response escapes.
  task automatic reset_window(input string tag);
    bit seen;
    rst_n = 1'b0;
    seen  = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check({tag, " rsp suppressed"}, 32'(seen), 32'd0);
    check_zero_outputs(tag);
  endtask

  task automatic start_read(input logic [3:0] a);
    int wait_n;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = 8'h00;
    bus.req_inj   = 12'h000;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [7:0]  rd;
    logic [3:0]  s;
    logic        c;
    logic        u;
    logic [11:0] inj;
    int          n;
    int          b1;
    int          b2;
    logic [3:0]  a;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 8'h00;
    bus.req_inj   = 12'h000;
    for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    release_reset("reset");

    do_write("t1 wr", 4'd3, 8'hA5, 12'h000);
    do_read("t1 rd", 4'd3);

    do_write("t2 wr", 4'd5, 8'h3C, 12'h004);
    do_read("t2 rd", 4'd5);
    do_read("t2 reread", 4'd5);

    do_write("t3 wr", 4'd1, 8'h00, 12'h801);
    do_read("t3 rd", 4'd1);
    do_read("t3 reread", 4'd1);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    release_reset("pre t4");
    for (int i = 0; i < 12; i++) begin
      do_write("t4 wr", 4'd2, 8'h5A, 12'(1) << i);
      do_read("t4 rd", 4'd2);
    end
    check("t4 final err_count", 32'(bus.err_count), 32'd12);

    // Second request held on the bus throughout a read.
    model_read(4'd3, rd, s, c, u);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd3;
    bus.req_inj   = 12'h000;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'd12;
    bus.req_wdata = 8'h77;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      check("t5 ready busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("t5 read latency", 32'(n), 32'd3);
    check("t5 read rdata", 32'(bus.rsp_rdata), 32'(rd));
    check("t5 ready at rsp", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    check("t5 ready idle", 32'(bus.req_ready), 32'd1);
    model_mem[12]   = model_enc(8'h77);
    model_valid[12] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("t5 accepted", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    check("t5 write rsp", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
    do_read("t5 readback", 4'd12);

    do_write("t6 wr7", 4'd7, 8'hC3, 12'h000);
    start_read(4'd7);
    reset_window("t6 rd");
    release_reset("t6 rd");
    do_read("t6 rd after", 4'd7);

    do_write("t6 wr9", 4'd9, 8'h96, 12'h040);
    start_read(4'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_window("t6 wb");
    release_reset("t6 wb");
    do_read("t6 wb after", 4'd9);
    do_read("t6 wb scrubbed", 4'd9);

    for (int it = 0; it < 60; it++) begin
      a = 4'($urandom_range(0, 15));
      if (!model_valid[a] || $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          1: inj = 12'(1) << $urandom_range(0, 11);
          2: begin
            b1 = $urandom_range(0, 11);
            b2 = (b1 + $urandom_range(1, 11)) % 12;
            inj = (12'(1) << b1) | (12'(1) << b2);
          end
          default: inj = 12'h000;
        endcase
        do_write("rand wr", a, 8'($urandom), inj);
      end else begin
        do_read("rand rd", a);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
